// File: rtl/offset_add_pkg.sv
// -----------------------------------------------------------------------------
// offset_add_pkg
//   Shared definitions for the offset_add_pipe block.
//   - mode_e  : per-transaction offset selector carried on in_mode.
//   - off_sel : elaboration-time helper that returns the offset selected by a
//               mode, already reduced modulo 2^width.
// -----------------------------------------------------------------------------
package offset_add_pkg;

  typedef enum logic [1:0] {
    MODE_LOCAL   = 2'd0,  // + P_LOCAL
    MODE_SUM     = 2'd1,  // + (P_BASE + P_LOCAL)
    MODE_BASE    = 2'd2,  // + P_BASE
    MODE_ILLEGAL = 2'd3   // + 0, flags err_mode
  } mode_e;

  // Offsets are evaluated in 32 bits. Any lane wider than that simply sees the
  // offset zero-extended, and for narrower lanes a 32-bit wrap of
  // p_base + p_local does not change the value modulo 2^width.
  localparam int unsigned OFF_CALC_W = 32;

  function automatic logic [OFF_CALC_W-1:0] off_sel(
    input mode_e       mode,
    input int unsigned p_base,
    input int unsigned p_local,
    input int unsigned width
  );
    logic [OFF_CALC_W-1:0] raw;
    logic [OFF_CALC_W-1:0] mask;
    raw = '0;
    case (mode)
      MODE_LOCAL: raw = OFF_CALC_W'(p_local);
      MODE_SUM:   raw = OFF_CALC_W'(p_base) + OFF_CALC_W'(p_local);
      MODE_BASE:  raw = OFF_CALC_W'(p_base);
      default:    raw = '0;
    endcase
    if (width >= OFF_CALC_W) begin
      mask = '1;
    end else begin
      mask = (OFF_CALC_W'(1) << width) - OFF_CALC_W'(1);
    end
    return raw & mask;
  endfunction

endpackage

// File: rtl/offset_add_fifo.sv
// -----------------------------------------------------------------------------
// offset_add_fifo
//   Synchronous single-clock FIFO with a combinational (fall-through) read of
//   the head entry. A write is accepted while full only if a read happens in
//   the same cycle, so a full FIFO can stream at one entry per clock.
//
//   Ports
//     clk      in   1      clock, all state on rising edge
//     rst_n    in   1      synchronous active-low reset (empties the FIFO)
//     wr_en    in   1      write request
//     wr_data  in   W      data written at the tail
//     rd_en    in   1      read request (ignored while empty)
//     rd_data  out  W      head entry; undefined content while empty
//     full     out  1      fill == DEPTH
//     empty    out  1      fill == 0
// -----------------------------------------------------------------------------
module offset_add_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          do_wr;
  logic          do_rd;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == DEPTH_CNT);
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is only legal when the head leaves this cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_wr) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_wr && !do_rd) begin
      fill_d = fill_q + CW'(1);
    end else if (!do_wr && do_rd) begin
      fill_d = fill_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by fill_q.
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/offset_add_pipe.sv
// -----------------------------------------------------------------------------
// offset_add_pipe
//   NCH-lane constant-offset adder behind a valid/ready handshake, buffered by
//   a DEPTH-entry output FIFO. in_mode picks one of three elaborated offsets
//   (P_LOCAL, P_BASE+P_LOCAL, P_BASE); mode 3 adds zero and raises a sticky
//   error flag. Each lane reports its carry-out; with SATURATE=1 a carrying
//   lane is clamped to all-ones.
//
//   Ports
//     clk        in   1          clock, all state on rising edge
//     rst_n      in   1          synchronous active-low reset
//     in_valid   in   1          input transaction valid
//     in_ready   out  1          !full | out_ready (combinational from out_ready)
//     in_data    in   NCH*WIDTH  lane k at [k*WIDTH +: WIDTH]
//     in_mode    in   2          offset selector (see mode_e)
//     out_valid  out  1          FIFO head valid
//     out_ready  in   1          consumer accepts the head
//     out_data   out  NCH*WIDTH  lane results, same packing as in_data
//     out_ovf    out  NCH        per-lane carry-out (before saturation)
//     err_mode   out  1          sticky: an accepted transaction used mode 3
//     txn_cnt    out  16         accepted transactions, wraps at 16 bits
// -----------------------------------------------------------------------------
module offset_add_pipe
  import offset_add_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NCH      = 3,
  parameter int unsigned P_BASE   = 23,
  parameter int unsigned P_LOCAL  = 42,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_ovf,
  output logic                 err_mode,
  output logic [15:0]          txn_cnt
);

  localparam int unsigned DW = NCH * WIDTH;
  localparam int unsigned FW = DW + NCH;  // FIFO entry: {ovf, data}

  localparam logic [WIDTH-1:0] OFF_LOCAL =
    WIDTH'(off_sel(MODE_LOCAL, P_BASE, P_LOCAL, WIDTH));
  localparam logic [WIDTH-1:0] OFF_SUM =
    WIDTH'(off_sel(MODE_SUM, P_BASE, P_LOCAL, WIDTH));
  localparam logic [WIDTH-1:0] OFF_BASE =
    WIDTH'(off_sel(MODE_BASE, P_BASE, P_LOCAL, WIDTH));

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_rd_data;
  logic [FW-1:0]    head_view;

  logic [WIDTH-1:0] lane_off;
  logic             mode_illegal;
  logic [DW-1:0]    lane_res;
  logic [NCH-1:0]   lane_ovf;

  logic             err_mode_q, err_mode_d;
  logic [15:0]      txn_cnt_q, txn_cnt_d;
  logic [FW-1:0]    last_q, last_d;

  // ---------------------------------------------------------------------------
  // Mode decode: all lanes share the same offset within a transaction.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_off     = '0;
    mode_illegal = 1'b0;
    case (mode_e'(in_mode))
      MODE_LOCAL: lane_off = OFF_LOCAL;
      MODE_SUM:   lane_off = OFF_SUM;
      MODE_BASE:  lane_off = OFF_BASE;
      default: begin
        lane_off     = '0;
        mode_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane adders. The carry is taken from a WIDTH+1 bit sum so it reflects the
  // true add, independent of whether the lane is later clamped.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      logic [WIDTH:0] sum;
      assign sum          = {1'b0, in_data[gi*WIDTH +: WIDTH]} + {1'b0, lane_off};
      assign lane_ovf[gi] = sum[WIDTH];
      assign lane_res[gi*WIDTH +: WIDTH] =
        ((SATURATE != 0) && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake. in_ready looks through to out_ready so a full FIFO can accept
  // a new entry in the same cycle its head is consumed.
  // ---------------------------------------------------------------------------
  assign in_ready  = !fifo_full || out_ready;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  offset_add_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({lane_ovf, lane_res}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // While empty the outputs show the most recently consumed entry rather than
  // whatever stale word sits under the read pointer.
  assign head_view = fifo_empty ? last_q : fifo_rd_data;
  assign out_data  = head_view[DW-1:0];
  assign out_ovf   = head_view[FW-1:DW];
  assign err_mode  = err_mode_q;
  assign txn_cnt   = txn_cnt_q;

  always_comb begin
    last_d     = last_q;
    err_mode_d = err_mode_q;
    txn_cnt_d  = txn_cnt_q;
    if (pop) begin
      last_d = fifo_rd_data;
    end
    if (push) begin
      txn_cnt_d = txn_cnt_q + 16'd1;
      if (mode_illegal) begin
        err_mode_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= '0;
      err_mode_q <= 1'b0;
      txn_cnt_q  <= '0;
    end else begin
      last_q     <= last_d;
      err_mode_q <= err_mode_d;
      txn_cnt_q  <= txn_cnt_d;
    end
  end

endmodule

// File: tb/tb_offset_add_pipe.sv
module tb_offset_add_pipe;

  typedef struct packed {
    logic [47:0] d;
    logic [3:0]  o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default DUT and saturating DUT share the input side and out_ready.
  logic        in_valid;
  logic [23:0] in_data;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic        in_ready,  in_ready_s;
  logic        out_valid, out_valid_s;
  logic [23:0] out_data,  out_data_s;
  logic [2:0]  out_ovf,   out_ovf_s;
  logic        err_mode,  err_mode_s;
  logic [15:0] txn_cnt,   txn_cnt_s;

  // Wide variant: NCH=4, WIDTH=12, DEPTH=4.
  logic        in_valid_w;
  logic [47:0] in_data_w;
  logic [1:0]  in_mode_w;
  logic        out_ready_w;
  logic        in_ready_w;
  logic        out_valid_w;
  logic [47:0] out_data_w;
  logic [3:0]  out_ovf_w;
  logic        err_mode_w;
  logic [15:0] txn_cnt_w;

  offset_add_pipe #(.WIDTH(8), .NCH(3), .P_BASE(23), .P_LOCAL(42), .SATURATE(0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .err_mode(err_mode), .txn_cnt(txn_cnt));

  offset_add_pipe #(.WIDTH(8), .NCH(3), .P_BASE(23), .P_LOCAL(42), .SATURATE(1), .DEPTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_ovf(out_ovf_s), .err_mode(err_mode_s), .txn_cnt(txn_cnt_s));

  offset_add_pipe #(.WIDTH(12), .NCH(4), .P_BASE(23), .P_LOCAL(42), .SATURATE(0), .DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w), .in_data(in_data_w),
    .in_mode(in_mode_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .err_mode(err_mode_w), .txn_cnt(txn_cnt_w));

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q0[$];
  exp_t qs[$];
  exp_t qw[$];
  logic [15:0] exp_txn;
  logic [15:0] exp_txn_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  function automatic exp_t mk(input logic [47:0] d, input logic [3:0] o);
    exp_t e;
    e.d = d;
    e.o = o;
    return e;
  endfunction

  // Reference for the default 8-bit, 3-lane configuration (offsets 0x2A/0x41/0x17).
  function automatic exp_t model0(input logic [23:0] d, input logic [1:0] m);
    exp_t e;
    logic [7:0] off;
    logic [8:0] s;
    case (m)
      2'd0:    off = 8'h2A;
      2'd1:    off = 8'h41;
      2'd2:    off = 8'h17;
      default: off = 8'h00;
    endcase
    e = '0;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, d[k*8 +: 8]} + {1'b0, off};
      e.d[k*8 +: 8] = s[7:0];
      e.o[k] = s[8];
    end
    return e;
  endfunction

  function automatic exp_t satx(input exp_t e);
    exp_t r;
    r = e;
    for (int k = 0; k < 3; k++) begin
      if (e.o[k]) r.d[k*8 +: 8] = 8'hFF;
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that pushed.
  task automatic send(input logic [23:0] d, input logic [1:0] m, input exp_t e);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        q0.push_back(e);
        qs.push_back(satx(e));
        exp_txn = exp_txn + 16'd1;
        done = 1'b1;
      end else if (n >= 60) begin
        fail_now("send_timeout");
        in_valid = 1'b0;
        done = 1'b1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    in_mode  = 2'd0;
  endtask

  task automatic send_w(input logic [47:0] d, input logic [1:0] m, input exp_t e);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid_w = 1'b1;
    in_data_w  = d;
    in_mode_w  = m;
    while (!done) begin
      @(negedge clk);
      if (in_ready_w) begin
        qw.push_back(e);
        exp_txn_w = exp_txn_w + 16'd1;
        done = 1'b1;
      end else if (n >= 60) begin
        fail_now("send_w_timeout");
        in_valid_w = 1'b0;
        done = 1'b1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    in_valid_w = 1'b0;
    in_data_w  = '0;
    in_mode_w  = 2'd0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + qs.size() + qw.size() != 0) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_all_seen", 64'(q0.size() + qs.size() + qw.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid_w = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q0.delete();
    qs.delete();
    qw.delete();
    exp_txn = '0;
    exp_txn_w = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: compare each beat the consumer takes against the queue head, and
  // check that a stalled head holds still.
  // ---------------------------------------------------------------------------
  logic        ps0 = 1'b0;
  logic [26:0] pv0;
  always @(negedge clk) begin : mon0
    exp_t e;
    if (ps0 && rst_n) chk("hold_d0", {out_valid, out_ovf, out_data}, {1'b1, pv0});
    if (rst_n && out_valid && out_ready) begin
      if (q0.size() == 0) fail_now("d0_unexpected_beat");
      else begin
        e = q0.pop_front();
        chk("d0_data", out_data, e.d[23:0]);
        chk("d0_ovf", out_ovf, e.o[2:0]);
      end
    end
    ps0 = rst_n && out_valid && !out_ready;
    pv0 = {out_ovf, out_data};
  end

  always @(negedge clk) begin : mon_s
    exp_t e;
    if (rst_n && out_valid_s && out_ready) begin
      if (qs.size() == 0) fail_now("sat_unexpected_beat");
      else begin
        e = qs.pop_front();
        chk("sat_data", out_data_s, e.d[23:0]);
        chk("sat_ovf", out_ovf_s, e.o[2:0]);
      end
    end
  end

  logic        psw = 1'b0;
  logic [51:0] pvw;
  always @(negedge clk) begin : mon_w
    exp_t e;
    if (psw && rst_n) chk("hold_w", {out_valid_w, out_ovf_w, out_data_w}, {1'b1, pvw});
    if (rst_n && out_valid_w && out_ready_w) begin
      if (qw.size() == 0) fail_now("w_unexpected_beat");
      else begin
        e = qw.pop_front();
        chk("w_data", out_data_w, e.d);
        chk("w_ovf", out_ovf_w, e.o);
      end
    end
    psw = rst_n && out_valid_w && !out_ready_w;
    pvw = {out_ovf_w, out_data_w};
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed vectors for the default DUT: {in_data, mode, expected data, expected ovf}.
  logic [23:0] v_d  [5] = '{24'h302010, 24'h302010, 24'h302010, 24'hBF05F0, 24'hFFD5D6};
  logic [1:0]  v_m  [5] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
  logic [23:0] v_ed [5] = '{24'h5A4A3A, 24'h716151, 24'h473727, 24'h004631, 24'h29FF00};
  logic [2:0]  v_eo [5] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b101};

  logic [47:0] w_d  = {12'hFD6, 12'hFF0, 12'h123, 12'h010};
  logic [1:0]  w_m  [3] = '{2'd0, 2'd1, 2'd2};
  logic [47:0] w_ed [3] = '{{12'h000, 12'h01A, 12'h14D, 12'h03A},
                            {12'h017, 12'h031, 12'h164, 12'h051},
                            {12'hFED, 12'h007, 12'h13A, 12'h027}};
  logic [3:0]  w_eo [3] = '{4'b1100, 4'b1100, 4'b0100};

  initial begin
    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    in_valid_w = 1'b0; in_data_w = '0; in_mode_w = '0; out_ready_w = 1'b0;
    exp_txn = '0; exp_txn_w = '0;
    do_reset();

    // Reset state.
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 24'h0);
    chk("rst_out_ovf", out_ovf, 3'b0);
    chk("rst_err_mode", err_mode, 1'b0);
    chk("rst_txn_cnt", txn_cnt, 16'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_w_out_valid", out_valid_w, 1'b0);

    // Modes 0/1/2, then carry and wrap boundaries (saturating copy checked too).
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(v_d[i], v_m[i], mk(48'(v_ed[i]), 4'(v_eo[i])));
      chk("latency_out_valid", out_valid, 1'b1);
      drain();
    end
    chk("empty_holds_last", out_data, 24'h29FF00);
    chk("empty_holds_last_sat", out_data_s, 24'hFFFFFF);
    chk("empty_out_valid", out_valid, 1'b0);

    // Backpressure: two entries fill the FIFO, third stalls, then in order.
    out_ready = 1'b0;
    send(24'hF01101, 2'd2, mk(48'h072818, 4'b100));
    send(24'hE91202, 2'd2, mk(48'h002919, 4'b100));
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_in_ready_sat", in_ready_s, 1'b0);
    in_valid = 1'b1; in_data = 24'h401303; in_mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("stall_txn_cnt", txn_cnt, exp_txn);
    out_ready = 1'b1;
    send(24'h401303, 2'd2, mk(48'h572A1A, 4'b000));
    drain();

    // Full FIFO with push and pop in the same cycle.
    out_ready = 1'b0;
    send(24'h030201, 2'd0, model0(24'h030201, 2'd0));
    send(24'h060504, 2'd1, model0(24'h060504, 2'd1));
    chk("t4_full", in_ready, 1'b0);
    out_ready = 1'b1;
    send(24'h090807, 2'd2, model0(24'h090807, 2'd2));
    out_ready = 1'b0;
    #1;
    chk("t4_still_full", in_ready, 1'b0);
    chk("t4_out_valid", out_valid, 1'b1);
    chk("t4_txn_cnt", txn_cnt, exp_txn);
    out_ready = 1'b1;
    drain();

    // Illegal mode passes data and sets the sticky flag.
    chk("err_before", err_mode, 1'b0);
    send(24'h776655, 2'd3, mk(48'h776655, 4'b000));
    chk("err_after_edge", err_mode, 1'b1);
    chk("err_after_edge_sat", err_mode_s, 1'b1);
    for (int i = 0; i < 10; i++) begin
      logic [23:0] d;
      d = {8'(i * 3), 8'(8'h80 + i), 8'(8'hD0 + i)};
      send(d, 2'd0, model0(d, 2'd0));
    end
    drain();
    chk("err_sticky", err_mode, 1'b1);

    // Mid-stream reset discards queued entries.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [23:0] d;
      d = 24'(i * 24'h010101 + 24'h112233);
      send(d, 2'(i % 3), model0(d, 2'(i % 3)));
    end
    drain();
    out_ready = 1'b0;
    send(24'h0A0B0C, 2'd3, mk(48'h0A0B0C, 4'b000));
    send(24'h010203, 2'd0, model0(24'h010203, 2'd0));
    chk("pre_rst_txn", txn_cnt, 16'd7);
    chk("pre_rst_err", err_mode, 1'b1);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q0.delete(); qs.delete(); qw.delete();
    exp_txn = '0; exp_txn_w = '0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_err", err_mode, 1'b0);
    chk("mid_rst_txn", txn_cnt, 16'h0);
    chk("mid_rst_txn_sat", txn_cnt_s, 16'h0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_data", out_data, 24'h0);
    chk("mid_rst_out_ovf", out_ovf, 3'b0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("discarded_never_emitted", out_valid, 1'b0);

    // Transaction counter wrap.
    for (int i = 0; i < 65535; i++) begin
      logic [23:0] d;
      d = 24'(i * 7919);
      send(d, 2'(i % 3), model0(d, 2'(i % 3)));
    end
    chk("wrap_ffff", txn_cnt, 16'hFFFF);
    send(24'h000000, 2'd0, model0(24'h000000, 2'd0));
    chk("wrap_zero", txn_cnt, 16'h0000);
    drain();

    // Wide variant: modes 0/1/2 with distinct lanes, then DEPTH=4 backpressure.
    do_reset();
    out_ready_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_w(w_d, w_m[i], mk(w_ed[i], w_eo[i]));
      chk("w_latency", out_valid_w, 1'b1);
      drain();
    end
    out_ready_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_w({12'(12'hFE9 + i), 12'(12'h800 + i), 12'(12'h100 + i), 12'(12'h001 + i)}, 2'd2,
             mk({12'(i), 12'(12'h817 + i), 12'(12'h117 + i), 12'(12'h018 + i)}, 4'b1000));
    end
    chk("w_full_in_ready", in_ready_w, 1'b0);
    in_valid_w = 1'b1; in_data_w = {12'hFED, 12'h804, 12'h104, 12'h005}; in_mode_w = 2'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("w_stall_in_ready", in_ready_w, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready_w = 1'b1;
    send_w({12'hFED, 12'h804, 12'h104, 12'h005}, 2'd2,
           mk({12'h004, 12'h81B, 12'h11B, 12'h01C}, 4'b1000));
    drain();
    chk("w_txn_cnt", txn_cnt_w, 16'd8);
    chk("w_err_mode", err_mode_w, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
